// File: rtl/mio_arbiter.sv
// Two-master arbiter for the shared single-port memory/IO bus.
// Latches one request, holds mem_en for MEM_LAT cycles and then returns a one-cycle ready pulse.
//
// state  | meaning
// IDLE   | bus free; arbitrate between cpu_req and aux_req (round-robin on tie)
// ACCESS | mem_en held; latched we/addr/wdata drive the bus; wait counter runs
// RESP   | one-cycle ready pulse to the granted master, then back to IDLE

module mio_arbiter #(
   parameter int unsigned MEM_LAT = 2   // legal range 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [31:0] aux_addr,
   input  logic [31:0] aux_wdata,
   output logic [31:0] aux_rdata,
   output logic        aux_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_aux_q, last_aux_d;
   logic [1:0]  grant_q, grant_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        cpu_ready_q, cpu_ready_d;
   logic        aux_ready_q, aux_ready_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] aux_rdata_q, aux_rdata_d;
   logic        win_aux;

   // Aux wins when it asks alone, or on a tie when the CPU was served last.
   assign win_aux = aux_req & (~cpu_req | ~last_aux_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_aux_d  = last_aux_q;
      grant_d     = grant_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ready_d = 1'b0;
      aux_ready_d = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      aux_rdata_d = aux_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req || aux_req) begin
               state_d     = ST_ACCESS;
               cnt_d       = LAT_LOAD;
               last_aux_d  = win_aux;
               grant_d     = win_aux ? 2'b10 : 2'b01;
               mem_en_d    = 1'b1;
               mem_we_d    = win_aux ? aux_we    : cpu_we;
               mem_addr_d  = win_aux ? aux_addr  : cpu_addr;
               mem_wdata_d = win_aux ? aux_wdata : cpu_wdata;
            end
         end

         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d  = ST_RESP;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               if (grant_q[1]) begin
                  aux_ready_d = 1'b1;
                  if (!mem_we_q) aux_rdata_d = mem_rdata;
               end else begin
                  cpu_ready_d = 1'b1;
                  if (!mem_we_q) cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end

         default: begin
            state_d  = ST_IDLE;
            grant_d  = 2'b00;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         last_aux_q  <= 1'b1;
         grant_q     <= 2'b00;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         cpu_ready_q <= 1'b0;
         aux_ready_q <= 1'b0;
         cpu_rdata_q <= 32'd0;
         aux_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_aux_q  <= last_aux_d;
         grant_q     <= grant_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ready_q <= cpu_ready_d;
         aux_ready_q <= aux_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         aux_rdata_q <= aux_rdata_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign aux_rdata = aux_rdata_q;
   assign aux_ready = aux_ready_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: cycle-exact bus checks plus a read-data scoreboard
// fed at request time and drained on each ready pulse.

module tb_mio_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, aux_req, aux_we;
   logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
   logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ready, aux_ready, mem_en, mem_we;
   logic [1:0]  grant;

   // Second/third builds for the latency extremes (CPU side only).
   logic        c1_req, c15_req;
   logic [31:0] c1_rdata, c15_rdata, a1_rdata, a15_rdata;
   logic        c1_ready, c15_ready, a1_ready, a15_ready;
   logic        m1_en, m15_en, m1_we, m15_we;
   logic [31:0] m1_addr, m15_addr, m1_wdata, m15_wdata, m1_rdata, m15_rdata;
   logic [1:0]  g1, g15;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] q_cpu[$];
   logic [31:0] q_aux[$];
   logic [31:0] exp_rd[2];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return a ^ 32'h8C01_0014;
   endfunction

   assign mem_rdata = mem_model(mem_addr);
   assign m1_rdata  = mem_model(m1_addr);
   assign m15_rdata = mem_model(m15_addr);

   mio_arbiter #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_rdata(aux_rdata), .aux_ready(aux_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant(grant)
   );

   mio_arbiter #(.MEM_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(32'h60), .cpu_wdata(32'd0),
      .cpu_rdata(c1_rdata), .cpu_ready(c1_ready),
      .aux_req(1'b0), .aux_we(1'b0), .aux_addr(32'd0), .aux_wdata(32'd0),
      .aux_rdata(a1_rdata), .aux_ready(a1_ready),
      .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata), .grant(g1)
   );

   mio_arbiter #(.MEM_LAT(15)) u_dut15 (
      .clk(clk), .reset(reset),
      .cpu_req(c15_req), .cpu_we(1'b0), .cpu_addr(32'h60), .cpu_wdata(32'd0),
      .cpu_rdata(c15_rdata), .cpu_ready(c15_ready),
      .aux_req(1'b0), .aux_we(1'b0), .aux_addr(32'd0), .aux_wdata(32'd0),
      .aux_rdata(a15_rdata), .aux_ready(a15_ready),
      .mem_en(m15_en), .mem_we(m15_we), .mem_addr(m15_addr), .mem_wdata(m15_wdata),
      .mem_rdata(m15_rdata), .grant(g15)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard drain: every ready pulse must match a pending request.
   always @(negedge clk) begin
      if (cpu_ready || aux_ready)
         chk("ready_overlap", 32'(cpu_ready & aux_ready), 32'd0);
      if (cpu_ready) begin
         chk("cpu_ready_expected", 32'(q_cpu.size() > 0), 32'd1);
         if (q_cpu.size() > 0) begin
            mon_exp = q_cpu.pop_front();
            chk("cpu_rdata", cpu_rdata, mon_exp);
         end
      end
      if (aux_ready) begin
         chk("aux_ready_expected", 32'(q_aux.size() > 0), 32'd1);
         if (q_aux.size() > 0) begin
            mon_exp = q_aux.pop_front();
            chk("aux_rdata", aux_rdata, mon_exp);
         end
      end
   end

   task automatic push_exp(input bit m, input bit we, input logic [31:0] addr);
      if (!we) exp_rd[m] = mem_model(addr);
      if (m) q_aux.push_back(exp_rd[m]);
      else   q_cpu.push_back(exp_rd[m]);
   endtask

   // One uncontended access from idle with per-cycle bus checks.
   task automatic do_access(input bit m, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit chg);
      @(negedge clk);
      if (m) begin aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = wdata; end
      else   begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
      push_exp(m, we, addr);
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         if (k <= LAT) begin
            chk("acc_mem_en", 32'(mem_en), 32'd1);
            chk("acc_mem_we", 32'(mem_we), 32'(we));
            chk("acc_mem_addr", mem_addr, addr);
            if (we) chk("acc_mem_wdata", mem_wdata, wdata);
            chk("acc_grant", 32'(grant), m ? 32'd2 : 32'd1);
            chk("acc_no_ready", 32'({cpu_ready, aux_ready}), 32'd0);
            if (chg && k == 1) begin
               if (m) aux_addr = addr + 32'h100;
               else   cpu_addr = addr + 32'h100;
            end
         end else begin
            chk("resp_mem_en", 32'(mem_en), 32'd0);
            chk("resp_mem_we", 32'(mem_we), 32'd0);
            chk("resp_ready", 32'(m ? aux_ready : cpu_ready), 32'd1);
            chk("resp_other_ready", 32'(m ? cpu_ready : aux_ready), 32'd0);
            if (m) aux_req = 1'b0; else cpu_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_ready", 32'({cpu_ready, aux_ready}), 32'd0);
   endtask

   initial begin
      int n, prev, k1, k15;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
      c1_req = 1'b0; c15_req = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_ready", 32'({cpu_ready, aux_ready}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_aux_rdata", aux_rdata, 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      reset = 1'b0;

      do_access(1'b0, 1'b0, 32'h0000_0004, 32'd0, 1'b0);
      chk("cpu_read_value", cpu_rdata, 32'h8C01_0010);
      do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      chk("cpu_write_keeps_rdata", cpu_rdata, 32'h8C01_0010);
      do_access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b1);
      do_access(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0);
      chk("aux_write_keeps_rdata", aux_rdata, mem_model(32'h100));

      // Both masters requesting continuously from reset.
      @(negedge clk);
      reset = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      @(negedge clk);
      chk("rst2_cpu_rdata", cpu_rdata, 32'd0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h40;
      for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, i[0] ? 32'h40 : 32'h20);
      reset = 1'b0;
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!mem_en && n < 20) begin @(negedge clk); n++; end
         chk("tie_mem_en_seen", 32'(mem_en), 32'd1);
         chk("tie_grant", 32'(grant), i[0] ? 32'd2 : 32'd1);
         n = 0;
         while (!(cpu_ready || aux_ready) && n < 20) begin @(negedge clk); n++; end
         chk("tie_ready_who", 32'({aux_ready, cpu_ready}), i[0] ? 32'd2 : 32'd1);
         if (prev >= 0) chk("tie_spacing", 32'(cyc - prev), 32'(LAT + 2));
         prev = cyc;
      end
      cpu_req = 1'b0; aux_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("tie_done_mem_en", 32'(mem_en), 32'd0);
      chk("tie_done_grant", 32'(grant), 32'd0);

      // Reset in the second ACCESS cycle aborts the access.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
      @(negedge clk);
      chk("abort_acc1", 32'(mem_en), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_mem_en_async", 32'(mem_en), 32'd0);
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_cpu_rdata", cpu_rdata, 32'd0);
      exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (2) @(negedge clk);
      chk("abort_no_ready", 32'({cpu_ready, aux_ready}), 32'd0);
      cpu_addr = 32'h30; aux_req = 1'b1; aux_addr = 32'h50; aux_we = 1'b0;
      push_exp(1'b0, 1'b0, 32'h30);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_grant", 32'(grant), 32'd1);
      n = 0;
      while (!cpu_ready && n < 20) begin @(negedge clk); n++; end
      chk("post_rst_cpu_ready", 32'(cpu_ready), 32'd1);
      cpu_req = 1'b0; aux_req = 1'b0;
      repeat (2) @(negedge clk);

      // Latency extremes.
      c1_req = 1'b1; c15_req = 1'b1;
      k1 = -1; k15 = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (c1_ready && k1 < 0) begin k1 = k; c1_req = 1'b0; end
         if (c15_ready && k15 < 0) begin k15 = k; c15_req = 1'b0; end
      end
      chk("lat1_ready_cycle", 32'(k1), 32'd2);
      chk("lat15_ready_cycle", 32'(k15), 32'd16);
      chk("lat1_rdata", c1_rdata, mem_model(32'h60));
      chk("lat15_rdata", c15_rdata, mem_model(32'h60));
      chk("sb_cpu_drained", 32'(q_cpu.size()), 32'd0);
      chk("sb_aux_drained", 32'(q_aux.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
